// File: rtl/cdb_fair_arbiter.sv
// CDB arbiter: grants up to N_SLOTS requesters per cycle, with one-cycle registered latency.
// Define CDB_ARB_STARVE_EN to add per-requester wait counters that promote starved requesters.
module cdb_fair_arbiter #(
    parameter int unsigned NUM_REQ      = 6,
    parameter int unsigned N_SLOTS      = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       flush,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [N_SLOTS*NUM_REQ-1:0] gnt_bus,
    output logic                       starve_active
);

    logic [NUM_REQ-1:0]         w_starved;
    logic [NUM_REQ-1:0]         w_gnt;
    logic [N_SLOTS*NUM_REQ-1:0] w_gnt_bus;
    logic                       w_starve_sel;

    logic [NUM_REQ-1:0]         r_gnt;
    logic [N_SLOTS*NUM_REQ-1:0] r_gnt_bus;
    logic                       r_starve;

    // Isolates the lowest set bit, i.e. the highest-priority candidate.
    function automatic logic [NUM_REQ-1:0] lowest_bit(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

`ifdef CDB_ARB_STARVE_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_wait_cnt [NUM_REQ];

    // Starved status comes from the registered count, not this cycle's update.
    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starved[i] = (r_wait_cnt[i] == LIMIT);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || flush) begin
                r_wait_cnt[i] <= '0;
            end else if (req[i] && !w_gnt[i]) begin
                r_wait_cnt[i] <= (r_wait_cnt[i] == LIMIT) ? LIMIT : r_wait_cnt[i] + CNT_W'(1);
            end else begin
                r_wait_cnt[i] <= '0;
            end
        end
    end
`else
    assign w_starved = '0;
`endif

    // Starved requesters are drained before normal ones, each group in index order.
    always_comb begin
        logic [NUM_REQ-1:0] v_hi;
        logic [NUM_REQ-1:0] v_lo;
        logic [NUM_REQ-1:0] v_row;
        v_hi      = req & w_starved;
        v_lo      = req & ~w_starved;
        v_row     = '0;
        w_gnt     = '0;
        w_gnt_bus = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            v_row = (v_hi != '0) ? lowest_bit(v_hi) : lowest_bit(v_lo);
            w_gnt_bus[k*NUM_REQ +: NUM_REQ] = v_row;
            w_gnt = w_gnt | v_row;
            v_hi  = v_hi & ~v_row;
            v_lo  = v_lo & ~v_row;
        end
        w_starve_sel = |(w_gnt & w_starved);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_gnt     <= '0;
            r_gnt_bus <= '0;
            r_starve  <= 1'b0;
        end else begin
            r_gnt     <= w_gnt;
            r_gnt_bus <= w_gnt_bus;
            r_starve  <= w_starve_sel;
        end
    end

    assign gnt           = r_gnt;
    assign gnt_bus       = r_gnt_bus;
    assign starve_active = r_starve;

endmodule

// File: doc/cdb_fair_arbiter.md
CDB_FAIR_ARBITER -- requirements
Module: cdb_fair_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6: number of functional-unit requesters; index 0 has the highest fixed priority.
REQ-002 Parameter N_SLOTS, default 2: number of CDB slots granted per cycle.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive denied cycles after which a requester is starved.
REQ-004 Parameter CNT_W, default 3: wait-counter width; must satisfy 2^CNT_W - 1 >= STARVE_LIMIT.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-FU request to broadcast on the CDB next cycle.
REQ-008 flush  input  1  mispredict recovery; discards state and pending grants.
REQ-009 gnt  output  NUM_REQ  registered OR of all slot grants.
REQ-010 gnt_bus  output  N_SLOTS x NUM_REQ  registered one-hot grant per slot; a slot row may be all-zero.
REQ-011 starve_active  output  1  registered; high when the current grant includes at least one starved requester.

Function
REQ-012 Combinational grant selection each cycle; gnt, gnt_bus and starve_active become visible on the next rising edge, giving one-cycle latency.
REQ-013 The candidate order is fixed. First come starved requesters with req high, in ascending index order. Then come the remaining requesters with req high, in ascending index order.
REQ-014 Slot k receives the k-th candidate. Slots with no candidate are zero. A requester is never granted in more than one slot.
REQ-015 gnt is the OR of all gnt_bus rows, and popcount(gnt) never exceeds N_SLOTS.
REQ-016 Wait counters, one per requester, update on the same clock edge as the grant registers.
REQ-017 For each wait counter: if req is high and the requester is not granted this cycle, increment the counter, saturating at STARVE_LIMIT.
REQ-018 A wait counter clears to 0 if the requester is granted this cycle or if its req is low.
REQ-019 A requester is starved when its counter equals STARVE_LIMIT. Starved status is taken from the registered counter value, never from the value being computed this cycle.
REQ-020 If starved requesters exceed N_SLOTS, the lowest-index starved requesters win. The losing starved requesters stay saturated.
REQ-021 When flush is high, the next cycle clears gnt, gnt_bus, starve_active and all counters. flush overrides req in that cycle.
REQ-022 When flush and reset are both asserted, the behaviour is identical to reset.
REQ-023 When req is all zero, the next cycle shows gnt all zero and gnt_bus all zero, and all counters are 0.

Reset
REQ-024 On reset, gnt, gnt_bus and starve_active are 0, and all wait counters are 0.
REQ-025 Reset asserted mid-operation discards pending grants. The first grant after reset deassertion appears one cycle after the first sampled req.

Configuration
REQ-026 Macro CDB_ARB_STARVE_EN controls whether starvation promotion is compiled in.
REQ-027 With CDB_ARB_STARVE_EN defined: wait counters and starvation promotion are implemented as specified in REQ-013 and REQ-016 to REQ-020.
REQ-028 Without CDB_ARB_STARVE_EN: wait counters are not instantiated. Selection is pure fixed priority by ascending index. starve_active is tied 0. REQ-012, REQ-014, REQ-015, REQ-021 and REQ-024 still hold.

Verification (defaults, CDB_ARB_STARVE_EN defined unless stated)
REQ-029 Fixed priority: req=6'b111111 for one cycle, flush=0. Next cycle requires gnt_bus[0]=6'b000001, gnt_bus[1]=6'b000010, gnt=6'b000011 and starve_active=0.
REQ-030 Starvation: hold req=6'b100011.
- For cycles 1 to 4 after the first sample, gnt must be 6'b000011.
- Bit 5's counter must reach 4 after its 4th denial.
- On the following grant, gnt_bus[0]=6'b100000, gnt_bus[1]=6'b000001 and starve_active=1.
- On the cycle after that, bit 5's counter is 0 and bit 1's counter is 1.
REQ-031 Flush: hold req=6'b111100 until counters for bits 4 and 5 are nonzero, then assert flush=1 for one cycle. The next cycle requires gnt=0, gnt_bus=0, starve_active=0 and all counters 0.
REQ-032 Sparse requests: req=6'b001000. Next cycle requires gnt_bus[0]=6'b001000 and gnt_bus[1]=0. Then req=0, and the cycle after requires gnt=0.
REQ-033 Reset mid-stream: during REQ-030 at the cycle when counter 5 reaches 3, assert reset for one cycle.
- Outputs and counters must be 0 the next cycle.
- With req=6'b100011 held again, the starved grant must be delayed a full 4 denials from that point.
REQ-034 Macro off: build without CDB_ARB_STARVE_EN and hold req=6'b100011 for 20 cycles. gnt must be 6'b000011 every cycle and starve_active must be 0 every cycle.
